// File: rtl/snes_reader.sv
// SNES controller poller: latches the pad, clocks out 16 serial bits and presents them
// as an active-high button word with a one-cycle valid strobe.
module snes_reader #(
   parameter int LATCH_CYC = 25,
   parameter int HALF_CYC  = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        snes_data_in,
   output logic        snes_latch,
   output logic        snes_clk,
   output logic [15:0] buttons,
   output logic        valid,
   output logic        busy
);

   localparam int MaxCyc = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int CntW   = $clog2(MaxCyc);
   localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYC - 1);
   localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StLow,
      StHigh,
      StDone
   } state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [CntW-1:0]   r_cnt;
   logic [CntW-1:0]   w_cnt_d;
   logic [3:0]        r_bit;
   logic [3:0]        w_bit_d;
   logic [15:0]       r_shift;
   logic [15:0]       w_shift_d;
   logic [1:0]        r_sync;
   logic [15:0]       r_buttons;
   logic              r_latch;
   logic              r_sclk;
   logic              r_valid;
   logic              r_busy;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt + 1'b1;
      w_bit_d   = r_bit;
      w_shift_d = r_shift;
      case (r_state)
         StIdle: begin
            w_cnt_d = '0;
            if (start) begin
               w_state_d = StLatch;
               w_shift_d = '0;
            end
         end
         StLatch: begin
            if (r_cnt == LatchLast) begin
               w_state_d = StLow;
               w_cnt_d   = '0;
               w_bit_d   = '0;
            end
         end
         StLow: begin
            // Sample at the end of the low phase so the pad has had the whole phase to settle.
            if (r_cnt == HalfLast) begin
               w_shift_d[r_bit] = ~r_sync[1];
               w_state_d        = StHigh;
               w_cnt_d          = '0;
            end
         end
         StHigh: begin
            if (r_cnt == HalfLast) begin
               w_cnt_d = '0;
               if (r_bit == 4'd15) begin
                  w_state_d = StDone;
               end else begin
                  w_bit_d   = r_bit + 4'd1;
                  w_state_d = StLow;
               end
            end
         end
         StDone: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so the pad lines come straight off flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_sync    <= '0;
         r_buttons <= '0;
         r_latch   <= 1'b0;
         r_sclk    <= 1'b1;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_bit   <= w_bit_d;
         r_shift <= w_shift_d;
         r_sync  <= {r_sync[0], snes_data_in};
         r_latch <= (w_state_d == StLatch);
         r_sclk  <= (w_state_d != StLow);
         r_valid <= (w_state_d == StDone);
         r_busy  <= (w_state_d != StIdle);
         if (w_state_d == StDone) begin
            r_buttons <= w_shift_d;
         end
      end
   end

   assign snes_latch = r_latch;
   assign snes_clk   = r_sclk;
   assign buttons    = r_buttons;
   assign valid      = r_valid;
   assign busy       = r_busy;

endmodule

// File: tb/tb_snes_reader.sv
// Directed bench for snes_reader: a behavioural pad drives serial data while frame timing,
// captured words and reset/start corner cases are checked against hand-computed values.
module tb_snes_reader;

   localparam int LatchCyc = 25;
   localparam int HalfCyc  = 6;
   localparam int FrameCyc = LatchCyc + 32 * HalfCyc + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        snes_data_in;
   logic        snes_latch;
   logic        snes_clk;
   logic [15:0] buttons;
   logic        valid;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Pad model state: raw line levels (0 = pressed), optional noise outside the low phases.
   logic [15:0] data_raw = 16'hFFFF;
   bit          noise    = 1'b0;
   int          idx      = 0;
   logic        prev_mclk = 1'b1;

   typedef struct {
      logic [15:0] data;
      bit          nz;
      int          mid;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[6];

   snes_reader #(
      .LATCH_CYC(LatchCyc),
      .HALF_CYC (HalfCyc)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .snes_data_in(snes_data_in),
      .snes_latch  (snes_latch),
      .snes_clk    (snes_clk),
      .buttons     (buttons),
      .valid       (valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // The pad reloads on latch and advances one bit on each rising edge of its clock.
   always @(negedge clk) begin
      if (snes_latch) idx = 0;
      else if (snes_clk && !prev_mclk) idx = idx + 1;
      prev_mclk = snes_clk;
      if (noise && (snes_clk || snes_latch)) snes_data_in = 1'($urandom_range(0, 1));
      else snes_data_in = (idx < 16) ? data_raw[idx] : 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic run_frame(input logic [15:0] d, input bit nz, input int mid,
                            input logic [15:0] exp);
      int latch_n, falls, badw, run, overlap, lat, busy_n;
      logic prevc;
      data_raw = d;
      noise    = nz;
      start    = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      latch_n = 0; falls = 0; badw = 0; run = 0; overlap = 0; lat = -1; prevc = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         start = (n == mid);
         if (snes_latch) latch_n++;
         if (snes_latch && !snes_clk) overlap++;
         if (prevc && !snes_clk) falls++;
         if (!snes_clk) run++;
         if (!prevc && snes_clk) begin
            if (run != HalfCyc) badw++;
            run = 0;
         end
         prevc = snes_clk;
         if (valid) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("latch_width", latch_n, LatchCyc);
      chk("clk_pulses", falls, 16);
      chk("clk_low_width_errs", badw, 0);
      chk("clk_during_latch", overlap, 0);
      chk("frame_latency", lat, FrameCyc);
      chk("buttons", {16'h0, buttons}, {16'h0, exp});
      @(negedge clk);
      chk("valid_one_cycle", {31'h0, valid}, 32'h0);
      chk("idle_after_done", {31'h0, busy}, 32'h0);
      if (mid > 0) begin
         busy_n = 0;
         repeat (30) begin
            @(negedge clk);
            if (busy) busy_n++;
         end
         chk("no_queued_poll", busy_n, 0);
      end
   endtask

   initial begin
      logic [15:0] b2b_data[3];
      logic [15:0] b2b_exp[3];
      int vcount, last, falls, valid_n, busy_n;
      logic prevc;

      vecs[0] = '{data: 16'hFFFF, nz: 1'b0, mid: 0,   exp: 16'h0000};
      vecs[1] = '{data: 16'hF7FE, nz: 1'b0, mid: 0,   exp: 16'h0801};
      vecs[2] = '{data: 16'h0000, nz: 1'b0, mid: 0,   exp: 16'hFFFF};
      vecs[3] = '{data: 16'h5A3C, nz: 1'b1, mid: 0,   exp: 16'hA5C3};
      vecs[4] = '{data: 16'hEDCB, nz: 1'b1, mid: 0,   exp: 16'h1234};
      vecs[5] = '{data: 16'hFF0F, nz: 1'b0, mid: 100, exp: 16'h00F0};
      b2b_data = '{16'hFFFF, 16'h00F0, 16'h0000};
      b2b_exp  = '{16'h0000, 16'hFF0F, 16'hFFFF};

      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_latch", {31'h0, snes_latch}, 32'h0);
      chk("rst_clk", {31'h0, snes_clk}, 32'h1);
      chk("rst_buttons", {16'h0, buttons}, 32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_start", {31'h0, busy}, 32'h0);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].data, vecs[i].nz, vecs[i].mid, vecs[i].exp);
         repeat (3) @(negedge clk);
      end
      noise = 1'b0;

      // start held high: three back-to-back frames with one idle cycle between them
      data_raw = b2b_data[0];
      start    = 1'b1;
      vcount   = 0;
      last     = 0;
      for (int n = 1; n <= 1000; n++) begin
         @(negedge clk);
         if (valid) begin
            chk("b2b_buttons", {16'h0, buttons}, {16'h0, b2b_exp[vcount]});
            if (vcount > 0) chk("b2b_spacing", n - last, FrameCyc + 1);
            last = n;
            vcount++;
            if (vcount < 3) data_raw = b2b_data[vcount];
            else begin
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      chk("b2b_frames", vcount, 3);
      repeat (5) @(negedge clk);
      chk("b2b_stops", {31'h0, busy}, 32'h0);

      // reset in the 7th low phase
      data_raw = 16'h1234;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      falls = 0;
      prevc = 1'b1;
      for (int n = 0; n < 300 && falls < 7; n++) begin
         if (prevc && !snes_clk) falls++;
         prevc = snes_clk;
         if (falls < 7) @(negedge clk);
      end
      chk("reach_7th_low", falls, 7);
      repeat (2) @(negedge clk);
      chk("in_low_phase", {31'h0, snes_clk}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_latch", {31'h0, snes_latch}, 32'h0);
      chk("midrst_clk", {31'h0, snes_clk}, 32'h1);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_buttons", {16'h0, buttons}, 32'h0);
      chk("midrst_valid", {31'h0, valid}, 32'h0);
      rst     = 1'b0;
      valid_n = 0;
      busy_n  = 0;
      repeat (300) begin
         @(negedge clk);
         if (valid) valid_n++;
         if (busy) busy_n++;
      end
      chk("midrst_no_valid", valid_n, 0);
      chk("midrst_no_restart", busy_n, 0);

      // rst wins over start in the same cycle
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("rst_prio_busy", {31'h0, busy}, 32'h0);
      chk("rst_prio_latch", {31'h0, snes_latch}, 32'h0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst_prio_idle", {31'h0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
